// File: rtl/spi_slave_tx.sv
// SPI mode-0 slave transmitter/receiver, oversampled in the clk domain.
// Shifts a DATA_W-bit word out on miso (MSB first) while assembling the word on mosi.
module spi_slave_tx #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              underrun,
  output logic              abort
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_n_sync, mosi_sync, fill;
  logic                   sclk_d, cs_n_d, armed;
  logic                   sclk_s, cs_n_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_n_rise, cs_n_fall;
  logic [0:0]             state;
  logic [CNT_W-1:0]       bitcnt;
  logic                   reload_pend, hold_full, load_word;
  logic [DATA_W-1:0]      hold, shift_tx, shift_rx;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_n_s    = cs_n_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_n_rise = cs_n_s & ~cs_n_d;
  assign cs_n_fall = ~cs_n_s & cs_n_d;

  // A word slot opens at frame start and at the first sclk fall after a completed word.
  assign load_word = ((state == IDLE) && cs_n_fall && armed) ||
                     ((state == ACTIVE) && !cs_n_rise && sclk_fall && reload_pend);

  assign miso     = shift_tx[DATA_W-1];
  assign miso_oe  = (state == ACTIVE);
  assign busy     = (state == ACTIVE);
  assign tx_ready = ~hold_full;

  // armed only rises once a pin-derived cs_n high has reached the synchroniser output,
  // so a cs_n held low across reset cannot start a frame from the preset value.
  always_ff @(posedge clk) begin
    // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      sclk_sync <= '0;
      cs_n_sync <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_n_d    <= 1'b1;
      fill      <= '0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_n_sync <= {cs_n_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      cs_n_d    <= cs_n_s;
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
      if (fill[SYNC_STAGES-1] && cs_n_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bitcnt      <= '0;
      reload_pend <= 1'b0;
      hold_full   <= 1'b0;
      hold        <= '0;
      shift_tx    <= '0;
      shift_rx    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      underrun    <= 1'b0;
      abort       <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      underrun <= 1'b0;
      abort    <= 1'b0;

      // Accept and load are exclusive: one needs hold empty, the other hold full.
      if (tx_valid && !hold_full) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end

      if (load_word) begin
        if (hold_full) begin
          shift_tx  <= hold;
          hold_full <= 1'b0;
        end else begin
          shift_tx <= '0;
          underrun <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (cs_n_fall && armed) begin
            state       <= ACTIVE;
            bitcnt      <= '0;
            reload_pend <= 1'b0;
          end
        end
        default: begin
          if (cs_n_rise) begin
            state       <= IDLE;
            bitcnt      <= '0;
            reload_pend <= 1'b0;
            shift_rx    <= '0;
            shift_tx    <= '0;
            if (bitcnt != '0) abort <= 1'b1;
          end else if (sclk_rise) begin
            shift_rx <= {shift_rx[DATA_W-2:0], mosi_s};
            if (bitcnt == LAST_BIT) begin
              rx_data     <= {shift_rx[DATA_W-2:0], mosi_s};
              rx_valid    <= 1'b1;
              bitcnt      <= '0;
              reload_pend <= 1'b1;
            end else begin
              bitcnt <= bitcnt + 1'b1;
            end
          end else if (sclk_fall) begin
            if (reload_pend) reload_pend <= 1'b0;
            else             shift_tx    <= {shift_tx[DATA_W-2:0], 1'b0};
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_tx.sv
// Self-checking bench for spi_slave_tx: an SPI mode-0 master model drives frames and
// compares the serial streams against words pushed and words sent, via a per-frame model.
module tb_spi_slave_tx;

  localparam int DATA_W = 32;
  localparam int HALF   = 40;   // sclk half period: 4 clk periods, i.e. f_clk/8

  logic              clk = 1'b0;
  logic              rst, sclk, cs_n, mosi, tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              miso, miso_oe, tx_ready, rx_valid, busy, underrun, abort;
  logic [DATA_W-1:0] rx_data;

  spi_slave_tx #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .underrun(underrun), .abort(abort)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Pulse monitor: counts events and records received words between clear_mon calls.
  int                rx_cnt, und_cnt, abt_cnt;
  bit                busy_seen;
  logic [DATA_W-1:0] rx_q[$];

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      rx_q.push_back(rx_data);
    end
    if (underrun) und_cnt++;
    if (abort)    abt_cnt++;
    if (busy)     busy_seen = 1'b1;
  end

  task automatic clear_mon();
    rx_cnt = 0; und_cnt = 0; abt_cnt = 0; busy_seen = 1'b0;
    rx_q.delete();
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    bit done = 1'b0;
    @(negedge clk);
    tx_data  = w;
    tx_valid = 1'b1;
    for (int i = 0; i < 2000 && !done; i++) begin
      if (tx_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    tx_valid = 1'b0;
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL push_word: tx_ready never rose, word %h not accepted", w);
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    #($urandom_range(1, 4));
    cs_n = 1'b0;
    #(2 * HALF);
  endtask

  task automatic clock_bits(input int n, input logic [63:0] mo, output logic [63:0] mi);
    mi = '0;
    for (int i = 0; i < n; i++) begin
      mosi = mo[n-1-i];
      #HALF;
      sclk = 1'b1;
      mi   = {mi[62:0], miso};
      #HALF;
      sclk = 1'b0;
    end
  endtask

  task automatic cs_high();
    #HALF;
    cs_n = 1'b1;
    mosi = 1'b0;
    #100;
  endtask

  task automatic frame(input int n, input logic [63:0] mo, output logic [63:0] mi);
    cs_low();
    clock_bits(n, mo, mi);
    cs_high();
  endtask

  logic [63:0]       mi, mo;
  logic [DATA_W-1:0] w, w2, last_rx;

  task automatic test_reset();
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({miso, miso_oe, tx_ready, rx_valid, busy, underrun, abort} !== 7'b0010000) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 0010000",
               {miso, miso_oe, tx_ready, rx_valid, busy, underrun, abort});
    end
    n_cmp++;
    if (rx_data !== '0) begin
      n_err++; $display("FAIL reset_rx_data: got %h expected 0", rx_data);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    clear_mon();
    push_word(32'hA5A5_0F0F);
    n_cmp++;
    if (tx_ready !== 1'b0) begin
      n_err++; $display("FAIL basic_hold_full: tx_ready %b expected 0", tx_ready);
    end
    cs_low();
    n_cmp++;
    if ({tx_ready, busy, miso_oe} !== 3'b111) begin
      n_err++; $display("FAIL basic_active: {tx_ready,busy,miso_oe} %b expected 111",
                        {tx_ready, busy, miso_oe});
    end
    clock_bits(32, 64'h1234_5678, mi);
    cs_high();
    n_cmp++;
    if (mi[31:0] !== 32'hA5A5_0F0F) begin
      n_err++; $display("FAIL basic_miso: got %h expected a5a50f0f", mi[31:0]);
    end
    n_cmp++;
    if (rx_cnt !== 1 || rx_data !== 32'h1234_5678) begin
      n_err++; $display("FAIL basic_rx: %0d pulses, rx_data %h expected 1 pulse, 12345678",
                        rx_cnt, rx_data);
    end
    // The sclk fall after the last bit opens the next word slot, which finds hold empty.
    n_cmp++;
    if (und_cnt !== 1 || abt_cnt !== 0) begin
      n_err++; $display("FAIL basic_events: underrun %0d abort %0d expected 1 and 0",
                        und_cnt, abt_cnt);
    end
    n_cmp++;
    if ({busy, miso_oe} !== 2'b00) begin
      n_err++; $display("FAIL basic_idle: {busy,miso_oe} %b expected 00", {busy, miso_oe});
    end
  endtask

  task automatic test_underrun();
    clear_mon();
    mo = {32'h0, $urandom()};
    frame(32, mo, mi);
    n_cmp++;
    if (mi[31:0] !== 32'h0) begin
      n_err++; $display("FAIL underrun_miso: got %h expected 0", mi[31:0]);
    end
    n_cmp++;
    if (rx_cnt !== 1 || rx_data !== mo[31:0]) begin
      n_err++; $display("FAIL underrun_rx: %0d pulses, rx_data %h expected 1 pulse, %h",
                        rx_cnt, rx_data, mo[31:0]);
    end
    n_cmp++;
    if (und_cnt !== 2) begin
      n_err++; $display("FAIL underrun_count: got %0d expected 2", und_cnt);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    push_word(32'h1111_1111);
    mo = {$urandom(), $urandom()};
    cs_low();
    fork
      clock_bits(64, mo, mi);
      begin
        #(2 * HALF * 8);
        push_word(32'h2222_2222);
      end
    join
    cs_high();
    last_rx = mo[31:0];
    n_cmp++;
    if (mi !== 64'h1111_1111_2222_2222) begin
      n_err++; $display("FAIL b2b_miso: got %h expected 1111111122222222", mi);
    end
    n_cmp++;
    if (rx_cnt !== 2 || rx_q.size() != 2 || rx_q[0] !== mo[63:32] || rx_q[1] !== mo[31:0]) begin
      n_err++; $display("FAIL b2b_rx: %0d pulses expected 2 with words %h %h",
                        rx_cnt, mo[63:32], mo[31:0]);
    end
    n_cmp++;
    if (und_cnt !== 1) begin
      n_err++; $display("FAIL b2b_underrun: got %0d expected 1", und_cnt);
    end
  endtask

  task automatic test_abort();
    clear_mon();
    w = $urandom();
    push_word(w);
    mo = {32'h0, $urandom()};
    frame(13, mo, mi);
    n_cmp++;
    if (mi[12:0] !== w[31:19]) begin
      n_err++; $display("FAIL abort_miso: got %h expected %h", mi[12:0], w[31:19]);
    end
    n_cmp++;
    if (abt_cnt !== 1 || rx_cnt !== 0) begin
      n_err++; $display("FAIL abort_events: abort %0d rx_valid %0d expected 1 and 0",
                        abt_cnt, rx_cnt);
    end
    n_cmp++;
    if (miso_oe !== 1'b0 || rx_data !== last_rx) begin
      n_err++; $display("FAIL abort_state: miso_oe %b rx_data %h expected 0, %h",
                        miso_oe, rx_data, last_rx);
    end
    clear_mon();
    w2 = $urandom();
    push_word(w2);
    mo = {32'h0, $urandom()};
    frame(32, mo, mi);
    n_cmp++;
    if (mi[31:0] !== w2 || rx_cnt !== 1 || rx_data !== mo[31:0] || abt_cnt !== 0) begin
      n_err++; $display("FAIL abort_recover: miso %h rx %h abort %0d expected %h, %h, 0",
                        mi[31:0], rx_data, abt_cnt, w2, mo[31:0]);
    end
  endtask

  task automatic test_reset_mid();
    push_word($urandom());
    cs_low();
    clock_bits(10, {32'h0, $urandom()}, mi);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({miso, miso_oe, tx_ready, rx_valid, busy, underrun, abort} !== 7'b0010000 ||
        rx_data !== '0) begin
      n_err++; $display("FAIL rstmid_outputs: flags %b rx_data %h expected 0010000, 0",
                        {miso, miso_oe, tx_ready, rx_valid, busy, underrun, abort}, rx_data);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    clock_bits(32, {32'h0, $urandom()}, mi);
    n_cmp++;
    if (busy_seen !== 1'b0 || miso_oe !== 1'b0 || rx_cnt !== 0 || und_cnt !== 0) begin
      n_err++; $display("FAIL rstmid_stay_idle: busy_seen %b miso_oe %b rx %0d und %0d expected all 0",
                        busy_seen, miso_oe, rx_cnt, und_cnt);
    end
    cs_high();
    clear_mon();
    w = $urandom();
    push_word(w);
    mo = {32'h0, $urandom()};
    frame(32, mo, mi);
    n_cmp++;
    if (mi[31:0] !== w || rx_cnt !== 1 || rx_data !== mo[31:0]) begin
      n_err++; $display("FAIL rstmid_recover: miso %h rx %h pulses %0d expected %h, %h, 1",
                        mi[31:0], rx_data, rx_cnt, w, mo[31:0]);
    end
  endtask

  task automatic test_hold_full();
    bit ready_seen = 1'b0;
    w  = $urandom();
    w2 = ~w;
    push_word(w);
    @(negedge clk);
    tx_data  = w2;
    tx_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (tx_ready) ready_seen = 1'b1;
    end
    tx_valid = 1'b0;
    n_cmp++;
    if (ready_seen !== 1'b0) begin
      n_err++; $display("FAIL holdfull_ready: tx_ready seen 1 expected 0 while hold full");
    end
    frame(32, 64'h0, mi);
    n_cmp++;
    if (mi[31:0] !== w) begin
      n_err++; $display("FAIL holdfull_no_overwrite: got %h expected %h", mi[31:0], w);
    end
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_err++; $display("FAIL holdfull_drained: tx_ready %b expected 1", tx_ready);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int k = 0; k < 200; k++) begin
      clear_mon();
      w  = $urandom();
      mo = {32'h0, $urandom()};
      push_word(w);
      frame(32, mo, mi);
      n_cmp++;
      if (mi[31:0] !== w || rx_q.size() != 1 || rx_q[0] !== mo[31:0]) begin
        n_err++;
        if (bad < 5)
          $display("FAIL random_frame %0d: miso %h rx pulses %0d expected %h and one rx %h",
                   k, mi[31:0], rx_q.size(), w, mo[31:0]);
        bad++;
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_hold_full();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
